// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's ROM, decode handshake and redirect signals.
// The master modport is the fetch unit; slave is the ROM/decode/control side.
interface fetch_unit_if;
  logic        start;
  logic [31:0] index;
  logic [31:0] instr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        halted;

  modport master (
    input  start, instr, id_ready, jump, jump_target, branch_taken, branch_imm,
    output index, if_valid, if_instr, if_pc, opcode, rs, rt, rd, shamt, funct, imm, halted
  );

  modport slave (
    output start, instr, id_ready, jump, jump_target, branch_taken, branch_imm,
    input  index, if_valid, if_instr, if_pc, opcode, rs, rt, rd, shamt, funct, imm, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a ROM_DEPTH-word ROM, holds one fetched word
// for decode, accepts jump/branch redirects and stops on the all-ones opcode.
module fetch_unit #(
  parameter int ROM_DEPTH = 16,
  parameter int RESET_PC  = 0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam int AW = $clog2(ROM_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic          valid_reg, valid_next;
  logic [31:0]   instr_reg, instr_next;
  logic [AW-1:0] ifpc_reg, ifpc_next;

  logic [31:0] jump_ext;
  logic [31:0] branch_sum;

  // Targets are formed at full 32-bit width and reduced to the ROM word range.
  assign jump_ext   = {6'b0, bus.jump_target};
  assign branch_sum = {{(32-AW){1'b0}}, ifpc_reg} + 32'd1
                    + {{16{bus.branch_imm[15]}}, bus.branch_imm};

  wire unused_upper = ^{jump_ext[31:AW], branch_sum[31:AW]};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    instr_next = instr_reg;
    ifpc_next  = ifpc_reg;
    case (state_reg)
      IDLE: begin
        pc_next    = AW'(RESET_PC);
        valid_next = 1'b0;
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        if (bus.jump) begin
          pc_next    = jump_ext[AW-1:0];
          valid_next = 1'b0;
        end else if (bus.branch_taken) begin
          pc_next    = branch_sum[AW-1:0];
          valid_next = 1'b0;
        end else if (!valid_reg || bus.id_ready) begin
          instr_next = bus.instr;
          ifpc_next  = pc_reg;
          valid_next = 1'b1;
          // The halt word is still delivered, but the PC parks on it.
          if (bus.instr[31:26] == HALT_OPCODE) state_next = HALT;
          else                                 pc_next    = pc_reg + AW'(1);
        end
      end
      HALT: begin
        if (valid_reg && bus.id_ready) valid_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= AW'(RESET_PC);
      valid_reg <= 1'b0;
      instr_reg <= 32'd0;
      ifpc_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      ifpc_reg  <= ifpc_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi = gi + 1) begin : g_pc_out
      if (gi < AW) begin : g_live
        assign bus.index[gi] = pc_reg[gi];
        assign bus.if_pc[gi] = ifpc_reg[gi];
      end else begin : g_zero
        assign bus.index[gi] = 1'b0;
        assign bus.if_pc[gi] = 1'b0;
      end
    end
  endgenerate

  assign bus.if_valid = valid_reg;
  assign bus.if_instr = instr_reg;
  assign bus.halted   = (state_reg == HALT);
  assign bus.opcode   = instr_reg[31:26];
  assign bus.rs       = instr_reg[25:21];
  assign bus.rt       = instr_reg[20:16];
  assign bus.rd       = instr_reg[15:11];
  assign bus.shamt    = instr_reg[10:6];
  assign bus.funct    = instr_reg[5:0];
  assign bus.imm      = instr_reg[15:0];
endmodule
